request_unit_burst: RTL

Parametrised successor to the CPU's single-word request unit. Sits between the datapath control and the memory/cache ports and generates req_iREN/req_dREN/req_dWEN. Adds the following over the single-word unit:
- multi-word (burst) data accesses with a word index
- optional instruction-fetch overlap during data access
- a no-response watchdog
- orderly halt that drains any in-flight burst before stopping.

---
 rtl/request_unit_burst.sv | 127 ++++++++++++
 1 files changed

// File: rtl/request_unit_burst.sv
// Burst-capable memory request unit: issues iREN/dREN/dWEN, steps a word
// index through data bursts, drains in-flight bursts on halt, flags stalls.
module request_unit_burst #(
    parameter int BW             = 4,
    parameter bit IFETCH_OVERLAP = 1'b0,
    parameter int TIMEOUT        = 64,
    parameter int TW             = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DataRead,
    input  logic          DataWrite,
    input  logic [BW-1:0] burst_len,
    input  logic          ihit,
    input  logic          dhit,
    input  logic          halt,
    output logic          req_iREN,
    output logic          req_dREN,
    output logic          req_dWEN,
    output logic [BW-1:0] word_idx,
    output logic          busy,
    output logic          halted,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE,
        DREQ,
        HALTED
    } state_t;

    localparam logic [BW-1:0] ONE_W   = BW'(1);
    localparam logic [TW-1:0] ONE_T   = TW'(1);
    localparam logic [TW-1:0] WD_MAX  = '1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic          TO_EN   = (TIMEOUT != 0);

    state_t        state_q, state_d;
    logic          op_wr_q, op_wr_d;
    logic [BW-1:0] len_q, len_d;
    logic [BW-1:0] idx_q, idx_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          hpend_q, hpend_d;
    logic          tmo_q, tmo_d;
    logic          stop_req;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
            hpend_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            hpend_q <= hpend_d;
            tmo_q   <= tmo_d;
        end
    end

    // A halt seen this cycle counts as pending even before it is latched.
    assign stop_req = hpend_q | halt;

    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        len_d    = len_q;
        idx_d    = idx_q;
        wdog_d   = wdog_q;
        hpend_d  = stop_req;
        tmo_d    = tmo_q;
        req_iREN = 1'b0;
        req_dREN = 1'b0;
        req_dWEN = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_iREN = 1'b1;
                if (stop_req) begin
                    state_d = HALTED;
                end else if (ihit && (DataRead || DataWrite)) begin
                    state_d = DREQ;
                    op_wr_d = DataWrite;
                    len_d   = (burst_len == '0) ? ONE_W : burst_len;
                    idx_d   = '0;
                    wdog_d  = '0;
                end
            end
            DREQ: begin
                busy     = 1'b1;
                req_iREN = IFETCH_OVERLAP;
                req_dREN = ~op_wr_q;
                req_dWEN = op_wr_q;
                if (dhit) begin
                    wdog_d = '0;
                    if (idx_q == len_q - ONE_W) begin
                        idx_d   = '0;
                        state_d = stop_req ? HALTED : IDLE;
                    end else begin
                        idx_d = idx_q + ONE_W;
                    end
                end else begin
                    if (wdog_q != WD_MAX) wdog_d = wdog_q + ONE_T;
                    if (TO_EN && (wdog_q == TO_LAST)) tmo_d = 1'b1;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign word_idx = idx_q;
    assign timeout  = tmo_q;

endmodule
